// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered ripple-borrow full subtractor; FULL_SUBTRACTOR_STATUS_EN adds zero/borrow_cnt status
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FULL_SUBTRACTOR_STATUS_EN
    ,
    output logic             zero,
    output logic [15:0]      borrow_cnt
`endif
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_next;

    // Ripple-borrow chain of single-bit full subtractor cells.
    always_comb begin
        borrow    = '0;
        diff_next = '0;
        borrow[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
            diff_next[i] = a[i] ^ b[i] ^ borrow[i];
            borrow[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff <= diff_next;
                bout <= borrow[WIDTH];
            end
        end
    end

`ifdef FULL_SUBTRACTOR_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero       <= 1'b0;
            borrow_cnt <= '0;
        end else if (in_valid) begin
            zero <= (diff_next == '0);
            // Saturate so a long-running count never wraps back to a small value.
            if (borrow[WIDTH] && (borrow_cnt != 16'hFFFF))
                borrow_cnt <= borrow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - directed self-checking bench for full_subtractor (WIDTH=1 and WIDTH=8)
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, bin1;
    logic       ov1, d1, bo1;
    logic       v8, bin8;
    logic [7:0] a8, b8, d8;
    logic       ov8, bo8;
`ifdef FULL_SUBTRACTOR_STATUS_EN
    logic        z1, z8;
    logic [15:0] cnt1, cnt8;
`endif

    int checks = 0;
    int errors = 0;

    // expected {diff,bout} for {a,b,bin} = 0..7
    logic [1:0] exp_tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic       exp_zero [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1), .bout(bo1)
`ifdef FULL_SUBTRACTOR_STATUS_EN
        , .zero(z1), .borrow_cnt(cnt1)
`endif
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8), .bout(bo8)
`ifdef FULL_SUBTRACTOR_STATUS_EN
        , .zero(z8), .borrow_cnt(cnt8)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [2:0] abc);
        @(negedge clk);
        v1 = v; a1 = abc[2]; b1 = abc[1]; bin1 = abc[0];
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bn);
        @(negedge clk);
        v8 = v; a8 = a; b8 = b; bin8 = bn;
    endtask

    task automatic chk1(input string tag, input logic d, input logic bo, input logic ov);
        chk({tag, ".diff"}, d1, d);
        chk({tag, ".bout"}, bo1, bo);
        chk({tag, ".out_valid"}, ov1, ov);
    endtask

    task automatic chk8(input string tag, input logic [7:0] d, input logic bo, input logic ov);
        chk({tag, ".diff"}, d8, d);
        chk({tag, ".bout"}, bo8, bo);
        chk({tag, ".out_valid"}, ov8, ov);
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; bin8 = 1'b0;

        // reset held two cycles with a live operation presented
        tick();
        chk1("rst_c0_w1", 1'b0, 1'b0, 1'b0);
        chk8("rst_c0_w8", 8'h00, 1'b0, 1'b0);
        tick();
        chk1("rst_c1_w1", 1'b0, 1'b0, 1'b0);
        chk8("rst_c1_w8", 8'h00, 1'b0, 1'b0);
`ifdef FULL_SUBTRACTOR_STATUS_EN
        chk("rst_cnt", cnt1, 16'd0);
        chk("rst_zero", z1, 1'b0);
`endif

        @(negedge clk);
        rst = 1'b0;
        v8  = 1'b0;

        // WIDTH=1 exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, 3'(i));
            tick();
            chk1($sformatf("sweep%0d", i), exp_tbl[i][1], exp_tbl[i][0], 1'b1);
`ifdef FULL_SUBTRACTOR_STATUS_EN
            chk($sformatf("sweep%0d.zero", i), z1, exp_zero[i]);
`endif
        end
`ifdef FULL_SUBTRACTOR_STATUS_EN
        chk("sweep_cnt", cnt1, 16'd4);
`endif

        // hold after 1-1-1 with in_valid low
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, 3'b000);
            tick();
            chk1($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0);
        end

        // WIDTH=8 boundary vectors
        drive8(1'b1, 8'h00, 8'h00, 1'b1);
        tick();
        chk8("w8_wrap", 8'hFF, 1'b1, 1'b1);
        drive8(1'b1, 8'hA5, 8'h25, 1'b0);
        tick();
        chk8("w8_a5m25", 8'h80, 1'b0, 1'b1);
        drive8(1'b1, 8'h10, 8'h10, 1'b0);
        tick();
        chk8("w8_equal", 8'h00, 1'b0, 1'b1);
        drive8(1'b1, 8'hFF, 8'h00, 1'b0);
        tick();
        chk8("w8_ones", 8'hFF, 1'b0, 1'b1);
        drive8(1'b0, 8'h37, 8'h99, 1'b1);
        tick();
        chk8("w8_hold", 8'hFF, 1'b0, 1'b0);

        // reset mid-stream
        drive1(1'b1, 3'b100);
        tick();
        chk1("pre_rst", 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b1;
        tick();
        chk1("mid_rst", 1'b0, 1'b0, 1'b0);
        chk8("mid_rst_w8", 8'h00, 1'b0, 1'b0);
`ifdef FULL_SUBTRACTOR_STATUS_EN
        chk("mid_rst_cnt", cnt1, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0; v1 = 1'b0;
        tick();
        chk1("post_rst_idle", 1'b0, 1'b0, 1'b0);
        drive1(1'b1, 3'b001);
        tick();
        chk1("resume", 1'b1, 1'b1, 1'b1);
`ifdef FULL_SUBTRACTOR_STATUS_EN
        chk("resume_cnt", cnt1, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
